muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers, sitting beside the ALU in the Execute stage of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from E, runs multi-cycle shift-add or restoring-divide iterations, and raises `busy` so the hazard unit can stall MFHI/MFLO and back-to-back mul/div in Decode. HI/LO are readable every cycle for MFHI/MFLO forwarding.

## Interface
- `WIDTH`, 32, operand and HI/LO width (≥ 4).
- `clk`  input  1  clock, rising-edge.
- `reset`  input  1  asynchronous, active-low reset.
- `startE`  input  1  issue strobe, sampled on rising edge.
- `opE`  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- `srcaE`  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- `srcbE`  input  WIDTH  rt operand (multiplier / divisor).
- `busy`  output  1  high while an iteration sequence is in flight.
- `done`  output  1  one-cycle pulse when HI/LO are updated by mul/div.
- `hi`  output  WIDTH  HI register.
- `lo`  output  WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, FIN.
- IDLE, `startE`=1:
  - MULT/MULTU: latch operands (absolute values for MULT), record the sign flag, counter=WIDTH, go to MUL.
  - DIV/DIVU: same, go to DIV.
  - MTHI/MTLO: write `srcaE` to HI/LO at that edge, stay IDLE, no `done`.
  - 110/111: ignored.
- MUL: one shift-add step per cycle on a 2·WIDTH accumulator; counter decrements; at 0 go to FIN.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); at 0 go to FIN.
- FIN (one cycle):
  - Product is negated if the signs differed (MULT only).
  - Quotient is negated if the signs differed. Remainder takes the dividend's sign (DIV only).
  - Write HI = upper product / remainder, LO = lower product / quotient.
  - Assert `done`, go to IDLE.
- Divide by zero: LO = all ones, HI = dividend (as given, signed or unsigned). Same fixed latency.
- Signed overflow (−2^(WIDTH−1) / −1): LO = −2^(WIDTH−1), HI = 0, from the normal datapath.
- `startE` while `busy`: ignored entirely, including MTHI/MTLO. The hazard unit guarantees this does not happen in legal flow.
- HI/LO hold their previous values during MUL/DIV; they change only at the FIN edge or on MTHI/MTLO.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0. Reset mid-operation aborts it; no `done`.
- Start sampled at edge T0.
- `busy`=1 from after T0 through the FIN cycle, i.e. WIDTH+1 cycles. It is combinational from state ≠ IDLE.
- HI/LO are updated at edge T0+WIDTH+1. `done` is high for the cycle following that edge, then `busy`=0.
- A new `startE` is accepted at edge T0+WIDTH+2 at the earliest.
- MTHI/MTLO take effect one edge after issue; `hi`/`lo` are visible in the next cycle.
- `busy` and `hi`/`lo` are registered-state-derived, with no combinational path from inputs.

## Configuration
- `MULDIV_DIV_EN` defined: DIV/DIVU are supported as described.
- `MULDIV_DIV_EN` undefined:
  - DIV state and divider datapath are compiled out.
  - DIV/DIVU are treated as no-ops: no `busy`, no `done`, HI/LO unchanged.
  - MULT/MULTU/MTHI/MTLO are unaffected.

## Structure
- Shared package `muldiv_pkg`: op encodings (`MD_MULT`…`MD_MTLO`), state encoding (IDLE/MUL/DIV/FIN), and a localparam for the counter width, $clog2(WIDTH+1).
- Single module; no sub-module. The hazard-unit stall term (`busy` & (MFHI/MFLO or mul/div in D)) lives in the hazard block, not here.

## Test plan
- MULT, −3 × 5 (WIDTH=32), `startE` at T0 -> `busy` for 33 cycles; at T0+33 HI=0xFFFFFFFF, LO=0xFFFFFFF1; `done` 1 cycle.
- MULTU, 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV, −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, 7 / 0 -> LO=0xFFFFFFFF, HI=0x00000007, same latency.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> HI=0x1234, LO=0x5678; `busy` and `done` stay 0.
- MULT issued, second MULT with different operands at T0+5 -> second ignored; result matches the first only.
- DIV issued, `reset` pulled low at T0+10 -> `busy`=0, HI=LO=0 immediately, no `done`. With `MULDIV_DIV_EN` undefined, DIV -> no `busy`, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------
// muldiv_pkg: op and state encodings shared by the mul/div unit
// Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam int MD_DEFAULT_WIDTH = 32;
  localparam int MD_CNT_W         = $clog2(MD_DEFAULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } md_state_t;

  function automatic int md_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------
// muldiv_unit: iterative shift-add multiply / restoring divide with HI/LO
// Divider built only when MULDIV_DIV_EN is defined.  Revision: 1.0
// ---------------------------------------------------------------
`default_nettype none

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [2:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CNT_W    = md_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t          state;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opa;
  logic               neg_res;
`ifdef MULDIV_DIV_EN
  logic               is_div;
  logic               neg_rem;
`endif

  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] fin_prod;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  assign busy      = (state != IDLE);
  assign signed_op = (opE == MD_MULT) || (opE == MD_DIV);
  assign a_neg     = signed_op & srcaE[WIDTH-1];
  assign b_neg     = signed_op & srcbE[WIDTH-1];
  assign abs_a     = a_neg ? -srcaE : srcaE;
  assign abs_b     = b_neg ? -srcbE : srcbE;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opa};

  always_comb begin
    fin_prod = neg_res ? -acc : acc;
    fin_hi   = fin_prod[2*WIDTH-1:WIDTH];
    fin_lo   = fin_prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      // Zero divisor: remainder path already reproduces the dividend, quotient forced
      fin_lo = (opa == '0) ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      fin_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      acc     <= '0;
      opa     <= '0;
      neg_res <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MULDIV_DIV_EN
      is_div  <= 1'b0;
      neg_rem <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (startE) begin
            case (opE)
              MD_MULT, MD_MULTU: begin
                state   <= MUL;
                count   <= CNT_LOAD;
                acc     <= {{WIDTH{1'b0}}, abs_b};
                opa     <= abs_a;
                neg_res <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                is_div  <= 1'b0;
`endif
              end
`ifdef MULDIV_DIV_EN
              MD_DIV, MD_DIVU: begin
                state   <= DIV;
                count   <= CNT_LOAD;
                acc     <= {{WIDTH{1'b0}}, abs_a};
                opa     <= abs_b;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                is_div  <= 1'b1;
              end
`endif
              MD_MTHI: hi <= srcaE;
              MD_MTLO: lo <= srcaE;
              default: ;
            endcase
          end
        end
        MUL: begin
          acc   <= {mul_sum, acc[WIDTH-1:1]};
          count <= count - CNT_ONE;
          if (count == CNT_ONE) state <= FIN;
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          if (div_trial[WIDTH])
            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          else
            acc <= {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          count <= count - CNT_ONE;
          if (count == CNT_ONE) state <= FIN;
        end
`endif
        FIN: begin
          hi    <= fin_hi;
          lo    <= fin_lo;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
`default_nettype none

module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         startE = 1'b0;
  logic [2:0]   opE = 3'b111;
  logic [W-1:0] srcaE = '0;
  logic [W-1:0] srcbE = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .startE(startE), .opE(opE),
    .srcaE(srcaE), .srcbE(srcbE), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    opE = op; srcaE = a; srcbE = b; startE = 1'b1;
    @(posedge clk);
    #1 startE = 1'b0; opE = 3'b111;
  endtask

  task automatic measure(input logic [W-1:0] pre_hi, input logic [W-1:0] pre_lo,
                         output int bcyc, output int didx, output int dcnt, output bit hold_ok);
    bcyc = 0; didx = -1; dcnt = 0; hold_ok = 1'b1;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bcyc++;
      if (done === 1'b1) begin
        dcnt++;
        if (didx < 0) didx = i;
      end
      if (busy === 1'b1 && (hi !== pre_hi || lo !== pre_lo)) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 0", lo); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_mthi_mtlo;
    bit quiet = 1'b1;
    issue(MD_MTHI, 32'h1234, 32'h0);
    if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
    issue(MD_MTLO, 32'h5678, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
    end
    checks++; if (hi !== 32'h1234) begin failures++; $display("FAIL mthi: got %h expected 00001234", hi); end
    checks++; if (lo !== 32'h5678) begin failures++; $display("FAIL mtlo: got %h expected 00005678", lo); end
    checks++; if (!quiet) begin failures++; $display("FAIL mt_quiet: busy/done raised, got 1 expected 0"); end
  endtask

  task automatic test_mult;
    int bc, di, dc; bit hold;
    issue(MD_MULT, -32'sd3, 32'sd5);
    measure(32'h1234, 32'h5678, bc, di, dc, hold);
    checks++; if (bc != W + 1) begin failures++; $display("FAIL mult_busy_cycles: got %0d expected %0d", bc, W + 1); end
    checks++; if (di != W + 1) begin failures++; $display("FAIL mult_done_pos: got %0d expected %0d", di, W + 1); end
    checks++; if (dc != 1) begin failures++; $display("FAIL mult_done_count: got %0d expected 1", dc); end
    checks++; if (!hold) begin failures++; $display("FAIL mult_hold: hi/lo changed while busy, got 0 expected 1"); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFF1) begin failures++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
  endtask

  task automatic test_multu;
    int bc, di, dc; bit hold;
    issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    measure(32'hFFFFFFFF, 32'hFFFFFFF1, bc, di, dc, hold);
    checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    checks++; if (bc != W + 1) begin failures++; $display("FAIL multu_busy_cycles: got %0d expected %0d", bc, W + 1); end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div;
    int bc, di, dc; bit hold;
    issue(MD_DIV, -32'sd7, 32'sd2);
    measure(32'hFFFFFFFE, 32'h00000001, bc, di, dc, hold);
    checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    checks++; if (di != W + 1 || dc != 1) begin failures++; $display("FAIL div_done: got pos %0d count %0d expected pos %0d count 1", di, dc, W + 1); end
    issue(MD_DIVU, 32'd7, 32'd0);
    measure(32'hFFFFFFFF, 32'hFFFFFFFD, bc, di, dc, hold);
    checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu0_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'h00000007) begin failures++; $display("FAIL divu0_hi: got %h expected 00000007", hi); end
    checks++; if (bc != W + 1 || di != W + 1) begin failures++; $display("FAIL divu0_latency: got busy %0d done %0d expected %0d", bc, di, W + 1); end
    issue(MD_DIV, -32'sd7, 32'd0);
    measure(32'h00000007, 32'hFFFFFFFF, bc, di, dc, hold);
    checks++; if (lo !== 32'hFFFFFFFF) begin failures++; $display("FAIL div0_lo: got %h expected ffffffff", lo); end
    checks++; if (hi !== 32'hFFFFFFF9) begin failures++; $display("FAIL div0_hi: got %h expected fffffff9", hi); end
    issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    measure(32'hFFFFFFF9, 32'hFFFFFFFF, bc, di, dc, hold);
    checks++; if (lo !== 32'h80000000) begin failures++; $display("FAIL divovf_lo: got %h expected 80000000", lo); end
    checks++; if (hi !== 32'h00000000) begin failures++; $display("FAIL divovf_hi: got %h expected 00000000", hi); end
    issue(MD_DIVU, 32'd100, 32'd7);
    measure(32'h0, 32'h80000000, bc, di, dc, hold);
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin failures++; $display("FAIL divu_basic: got hi %h lo %h expected hi 00000002 lo 0000000e", hi, lo); end
  endtask
`else
  task automatic test_div_disabled;
    bit quiet = 1'b1;
    issue(MD_DIV, -32'sd7, 32'sd2);
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin failures++; $display("FAIL div_off_quiet: busy/done raised, got 1 expected 0"); end
    checks++; if (hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL div_off_hi: got %h expected fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin failures++; $display("FAIL div_off_lo: got %h expected 00000001", lo); end
  endtask
`endif

  task automatic test_busy_ignore;
    int waited = 0;
    issue(MD_MULT, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    issue(MD_MULT, 32'd100, 32'd100);
    issue(MD_MTHI, 32'hDEAD, 32'h0);
    while (done !== 1'b1 && waited < W + 8) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL ignore_timeout: done got %b expected 1", done); end
    checks++; if (hi !== 32'h0 || lo !== 32'd42) begin failures++; $display("FAIL ignore_result: got hi %h lo %h expected hi 00000000 lo 0000002a", hi, lo); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignore_idle: busy got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int bc, di, dc; bit hold;
    issue(MD_MULTU, 32'd2, 32'd3);
    repeat (W) @(negedge clk);
    issue(MD_MTHI, 32'h99, 32'h0);
    checks++; if (done !== 1'b1 || hi !== 32'h0 || lo !== 32'd6) begin failures++; $display("FAIL b2b_first: got done %b hi %h lo %h expected 1 00000000 00000006", done, hi, lo); end
    issue(MD_MULTU, 32'd5, 32'd5);
    measure(32'h0, 32'd6, bc, di, dc, hold);
    checks++; if (bc != W + 1) begin failures++; $display("FAIL b2b_accept: busy cycles got %0d expected %0d", bc, W + 1); end
    checks++; if (lo !== 32'd25 || hi !== 32'h0) begin failures++; $display("FAIL b2b_second: got hi %h lo %h expected 00000000 00000019", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int dcnt = 0;
    issue(MD_MTHI, 32'h1111, 32'h0);
    issue(MD_MTLO, 32'h2222, 32'h0);
`ifdef MULDIV_DIV_EN
    issue(MD_DIV, 32'd1000, 32'd3);
`else
    issue(MD_MULT, 32'd1000, 32'd3);
`endif
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL midreset_hilo: got hi %h lo %h expected 0 0", hi, lo); end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    checks++; if (dcnt != 0) begin failures++; $display("FAIL midreset_nodone: got %0d active cycles expected 0", dcnt); end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_multu();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
